jk_mod_counter: RTL



---
 rtl/jk_pkg.sv | 29 ++
 rtl/jk_mod_counter_if.sv | 30 +++
 rtl/jk_cell.sv | 38 +++
 rtl/jk_mod_counter.sv | 94 +++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types for the JK counter slice: per-bit JK operation encoding,
// run-mode constants and the single-bit JK next-state helper.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TOG  = 2'b11
  } jk_op_e;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_JK    = 1'b1;

  // Next value of one JK bit for a given {J,K} operation.
  function automatic logic jk_next(input jk_op_e op, input logic q);
    logic nxt;
    nxt = q;
    case (op)
      HOLD:    nxt = q;
      CLR:     nxt = 1'b0;
      SET:     nxt = 1'b1;
      TOG:     nxt = ~q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/data bundle of the JK modulo counter; master drives controls,
// slave (the counter) returns register state and status pulses.
interface jk_mod_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             en;
  logic             mode;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, mode, up_dn, load, load_val, j, k,
    input  q, qn, tc, wrap, load_err
  );

  modport slave (
    input  en, mode, up_dn, load, load_val, j, k,
    output q, qn, tc, wrap, load_err
  );

endinterface

// File: rtl/jk_cell.sv
// Single JK storage bit with synchronous reset and a parallel-load path
// that overrides J/K; qn is registered alongside q.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic load_d,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = load_d;
    end else if (en) begin
      q_nxt = jk_next(jk_op_e'({j, k}), q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q  <= 1'b0;
      qn <= 1'b1;
    end else begin
      q  <= q_nxt;
      qn <= ~q_nxt;
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// WIDTH-bit register of JK cells: modulo up/down counter (mode 0) or direct
// per-bit JK (mode 1). Define JK_MOD_COUNTER_SAT_EN to saturate instead of wrap.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic           clk,
  input  logic           reset,
  jk_mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic [WIDTH-1:0] cell_ld_d;
  logic [WIDTH-1:0] limit_tgt;
  logic             in_range;
  logic             at_limit;
  logic             counting;
  logic             force_ld;
  logic             cell_ld;
  logic             wrap_set;
  logic             wrap_q;
  logic             load_err_q;

  assign in_range = ({1'b0, bus.load_val} < MOD_EXT);
  assign at_limit = bus.up_dn ? (q >= MAX_Q) : (q == '0);
  assign counting = bus.en & (bus.mode == MODE_COUNT) & ~bus.load;
  assign force_ld = counting & at_limit;

`ifdef JK_MOD_COUNTER_SAT_EN
  assign limit_tgt = bus.up_dn ? MAX_Q : '0;
  assign wrap_set  = 1'b0;
`else
  assign limit_tgt = bus.up_dn ? '0 : MAX_Q;
  assign wrap_set  = force_ld;
`endif

  // Limit crossings reuse the cell load path; user load wins over it.
  assign cell_ld   = bus.load | force_ld;
  assign cell_ld_d = bus.load ? (in_range ? bus.load_val : MAX_Q) : limit_tgt;

  // Ripple toggle mask for +/-1: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin : p_tog
    logic carry;
    carry = 1'b1;
    tog   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      tog[i] = carry;
      carry  = carry & (bus.up_dn ? q[i] : ~q[i]);
    end
  end

  assign cell_j = (bus.mode == MODE_JK) ? bus.j : tog;
  assign cell_k = (bus.mode == MODE_JK) ? bus.k : tog;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    jk_cell u_cell (
      .clk    (clk),
      .reset  (reset),
      .load   (cell_ld),
      .load_d (cell_ld_d[i]),
      .en     (bus.en),
      .j      (cell_j[i]),
      .k      (cell_k[i]),
      .q      (q[i]),
      .qn     (qn[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_set;
      load_err_q <= bus.load & ~in_range;
    end
  end

  assign bus.q        = q;
  assign bus.qn       = qn;
  assign bus.tc       = counting & at_limit;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule
